fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly downstream of the program counter and upstream of decode/execute. It reads the current PC value, fetches instruction words from an instruction ROM over a req/ack handshake with arbitrary wait states, and buffers up to two words. It presents them to decode over a valid/ready handshake. It drives the program counter's `inc`, `load` and `in` controls, including jump redirection and discarding of stale fetches.

## Interface
- `ADDR_W`, 16, instruction address width (PC width)
- `DATA_W`, 16, instruction word width
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `pc_in`  in  ADDR_W  current program counter value
- `pc_inc`  out  1  advance PC by 1 at this edge
- `pc_load`  out  1  load `pc_target` into PC at this edge; overrides `pc_inc`
- `pc_target`  out  ADDR_W  jump target for PC
- `rom_req`  out  1  fetch request, held until acknowledged
- `rom_addr`  out  ADDR_W  fetch address, stable while `rom_req`=1
- `rom_ack`  in  1  ROM data valid; meaningful only while `rom_req`=1
- `rom_data`  in  DATA_W  fetched word
- `instr_valid`  out  1  head instruction available
- `instr_ready`  in  1  decode accepts head instruction
- `instr`  out  DATA_W  head instruction word
- `instr_addr`  out  ADDR_W  address of head instruction
- `jump`  in  1  redirect; sampled only on an accept cycle
- `jump_addr`  in  ADDR_W  redirect target

## Operation
- Reset (`reset`=0 at an edge):
  - `rom_req`, `instr_valid`, and buffer count go to 0.
  - `rom_addr`, `instr`, `instr_addr` go to 0. `drop_pending` goes to 0.
  - Any outstanding request is abandoned.
  - The PC is reset by its own reset, tied to the same system reset at top level.
- First request: `rom_req`=1 with `rom_addr`=`pc_in` on the first cycle after `reset` returns to 1.
- Ack (`rom_req & rom_ack`) with `drop_pending`=0:
  - Writes {`rom_data`, `rom_addr`} into the buffer.
  - `pc_inc`=1 in that same cycle (combinational).
- Request continuation at each ack edge:
  - If the post-edge count ≤ 1, `rom_req` stays 1 and `rom_addr` ← `rom_addr`+1 (mod 2^ADDR_W).
  - Otherwise `rom_req` ← 0.
- New request: launched, with `rom_addr` ← `pc_in`, whenever the buffer count ≤ 1 and no request is outstanding.
- At most one request is outstanding.
- Accept: `instr_valid & instr_ready` pops the head. A simultaneous push and pop keeps the count unchanged.
- Jump accept (accept & `jump`):
  - `pc_load`=1 and `pc_target`=`jump_addr` combinationally. `pc_inc` is forced to 0.
  - The buffer is flushed (count ← 0).
  - If a request is outstanding and not acked this cycle: `drop_pending` ← 1 and `rom_req` stays 1 until ack.
  - Otherwise: `rom_req` ← 1 and `rom_addr` ← `jump_addr`.
- Ack with `drop_pending`=1:
  - Data is discarded and `pc_inc`=0.
  - `drop_pending` ← 0, `rom_addr` ← `pc_in`, `rom_req` stays 1.
- Ack in the same cycle as a jump accept: data is discarded and `pc_load` wins; no `drop_pending` is set.
- `jump` outside an accept cycle is ignored.
- `pc_inc` and `pc_load` are never both 1.

## Timing
- Latency, zero-wait ROM (ack in the same cycle as req): `instr_valid` goes to 1 one cycle after the ack edge.
- Throughput: 1 instruction per cycle sustained with zero-wait ROM and `instr_ready` held at 1.
- Redirect penalty:
  - Jump accept at edge N gives the first target instruction valid at N+2 with zero-wait ROM.
  - With an outstanding stale request, add the stale request's remaining wait cycles.
- Buffer full (count=2, no pop): no new request is launched; an outstanding request never exists in this state.
- `instr`/`instr_addr` hold their value while `instr_valid`=1 and `instr_ready`=0.
- `pc_inc`, `pc_load`, `pc_target` are combinational from the current inputs and state. All other outputs are registered.

## Structure
- Shared header `fetch_defs.vh` with an include guard holds:
  - `ADDR_W`/`DATA_W` defaults
  - the count encoding (0, 1, 2)
  - the reset address constant (0)
- Sub-module `fetch_buffer`: a 2-entry FIFO of {addr, word} with push, pop, flush, count.
- `fetch_unit` holds the request control, `drop_pending`, and the PC control outputs.

## Test plan
- Reset with PC=0, zero-wait ROM holding 0x1111, 0x2222, 0x3333 at addresses 0, 1, 2, ready=1:
  - `instr` sequence 0x1111/0, 0x2222/1, 0x3333/2 on consecutive cycles.
  - `pc_inc`=1 on each ack.
- ROM with 3 wait states: each request is held with a stable `rom_addr` for 4 cycles; one instruction is delivered per 4 cycles.
- `instr_ready`=0 for 10 cycles: count saturates at 2, `rom_req`=0, and `instr` is stable. Releasing ready delivers the words in order with no loss or duplication.
- Jump accept at head addr 5 with `jump_addr`=0x0040 and no outstanding request:
  - `pc_load`=1 with `pc_target`=0x0040; buffered addr 6 is flushed.
  - Next `rom_addr`=0x0040, and the next instruction has addr 0x0040.
- Jump while a 2-wait request to addr 7 is outstanding:
  - The ack for addr 7 is dropped with `pc_inc`=0.
  - The next request is to the target, and no addr-7 instruction is presented.
- Assert reset mid-wait, then ROM ack arrives: the ack is ignored, all outputs are at reset values, and fetch restarts from `pc_in`.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   ADDR_W_DEF / DATA_W_DEF : default address and instruction word widths
//   CNT_*                   : fetch buffer occupancy encoding (0, 1, 2)
//   BUF_DEPTH               : number of buffered instruction words
//   RESET_ADDR              : value address registers take at reset
package fetch_unit_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  localparam int BUF_DEPTH  = 2;
  localparam int RESET_ADDR = 0;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {addr, word} pairs feeding decode.
// Entry 0 is always the head, so head_addr/head_word come straight from
// registers and hold while nothing is popped.
//   clk, reset            : clock, synchronous active-low reset
//   push, push_addr/word  : write one entry
//   pop                   : remove the head entry
//   flush                 : empty the buffer (wins over push/pop)
//   count                 : occupancy (0..2)
//   head_addr, head_word  : current head entry
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_word,
  output logic [1:0]        count,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_word
);

  logic [1:0]        count_reg, count_next;
  logic [1:0]        slot;
  logic [ADDR_W-1:0] addr_reg  [BUF_DEPTH];
  logic [ADDR_W-1:0] addr_next [BUF_DEPTH];
  logic [DATA_W-1:0] word_reg  [BUF_DEPTH];
  logic [DATA_W-1:0] word_next [BUF_DEPTH];

  // A pop shifts everything down one place first, so the pushed word lands
  // in the slot just past the surviving entries.
  always_comb begin
    count_next = count_reg;
    slot       = pop ? (count_reg - 2'd1) : count_reg;
    if (flush) begin
      count_next = CNT_EMPTY;
    end else if (push && !pop && count_reg != CNT_FULL) begin
      count_next = count_reg + 2'd1;
    end else if (pop && !push && count_reg != CNT_EMPTY) begin
      count_next = count_reg - 2'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      logic load_new;
      assign load_new = push && !flush && (slot == 2'(gi));
      if (gi < BUF_DEPTH - 1) begin : g_shift
        assign addr_next[gi] = load_new ? push_addr : (pop ? addr_reg[gi+1] : addr_reg[gi]);
        assign word_next[gi] = load_new ? push_word : (pop ? word_reg[gi+1] : word_reg[gi]);
      end else begin : g_tail
        assign addr_next[gi] = load_new ? push_addr : addr_reg[gi];
        assign word_next[gi] = load_new ? push_word : word_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= CNT_EMPTY;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        addr_reg[i] <= ADDR_W'(RESET_ADDR);
        word_reg[i] <= '0;
      end
    end else begin
      count_reg <= count_next;
      addr_reg  <= addr_next;
      word_reg  <= word_next;
    end
  end

  assign count     = count_reg;
  assign head_addr = addr_reg[0];
  assign head_word = word_reg[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage between the program counter and decode.
// Fetches words from the instruction ROM (req/ack, any number of wait
// states), buffers up to two, and hands them to decode (valid/ready).
// Drives the PC's inc/load/target controls, including jump redirection
// and discarding of a fetch that was already in flight at the jump.
//   clk, reset                : clock, synchronous active-low reset
//   pc_in                     : current PC value
//   pc_inc, pc_load, pc_target: PC controls (combinational)
//   rom_req, rom_addr         : fetch request, held until rom_ack
//   rom_ack, rom_data         : ROM response
//   instr_valid/ready         : decode handshake
//   instr, instr_addr         : head instruction and its address
//   jump, jump_addr           : redirect, honoured only on an accept cycle
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr
);

  logic              rom_req_reg, rom_req_next;
  logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
  logic              drop_pending_reg, drop_pending_next;
  logic [1:0]        count, count_after;
  logic              ack, accept, jump_accept, push;

  assign ack         = rom_req_reg & rom_ack;
  assign accept      = instr_valid & instr_ready;
  assign jump_accept = accept & jump;
  // Data arriving with a jump accept, or for a request issued before an
  // earlier jump, belongs to the abandoned path and is not kept.
  assign push        = ack & ~drop_pending_reg & ~jump_accept;

  assign pc_inc    = push;
  assign pc_load   = jump_accept;
  assign pc_target = jump_addr;

  // Occupancy once this edge's push/pop/flush have taken effect.
  assign count_after = jump_accept ? CNT_EMPTY
                     : (count + {1'b0, push} - {1'b0, accept});

  always_comb begin
    rom_req_next      = rom_req_reg;
    rom_addr_next     = rom_addr_reg;
    drop_pending_next = drop_pending_reg;
    if (jump_accept) begin
      if (rom_req_reg && !rom_ack) begin
        // Request must complete before a new one can go out; remember to
        // throw its data away.
        drop_pending_next = 1'b1;
      end else begin
        rom_req_next      = 1'b1;
        rom_addr_next     = jump_addr;
        drop_pending_next = 1'b0;
      end
    end else if (ack) begin
      if (drop_pending_reg) begin
        // PC was loaded with the target at the jump, so pc_in points there.
        drop_pending_next = 1'b0;
        rom_addr_next     = pc_in;
      end else if (count_after <= CNT_ONE) begin
        rom_addr_next = rom_addr_reg + ADDR_W'(1);
      end else begin
        rom_req_next = 1'b0;
      end
    end else if (!rom_req_reg && count <= CNT_ONE) begin
      rom_req_next  = 1'b1;
      rom_addr_next = pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rom_req_reg      <= 1'b0;
      rom_addr_reg     <= ADDR_W'(RESET_ADDR);
      drop_pending_reg <= 1'b0;
    end else begin
      rom_req_reg      <= rom_req_next;
      rom_addr_reg     <= rom_addr_next;
      drop_pending_reg <= drop_pending_next;
    end
  end

  fetch_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (accept),
    .flush     (jump_accept),
    .push_addr (rom_addr_reg),
    .push_word (rom_data),
    .count     (count),
    .head_addr (instr_addr),
    .head_word (instr)
  );

  assign rom_req     = rom_req_reg;
  assign rom_addr    = rom_addr_reg;
  assign instr_valid = (count != CNT_EMPTY);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [15:0] pc_in;
  logic        pc_inc, pc_load;
  logic [15:0] pc_target;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr, instr_addr;
  logic        jump;
  logic [15:0] jump_addr;

  fetch_unit dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_target(pc_target), .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
    .rom_data(rom_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_addr(instr_addr), .jump(jump), .jump_addr(jump_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int accepts = 0;

  // ROM contents: 0x1111, 0x2222, 0x3333, ... (word = 0x1111*(addr+1)).
  function automatic logic [15:0] rom_word(input logic [15:0] a);
    logic [31:0] p;
    p = 32'h1111 * ({16'h0, a} + 32'd1);
    return p[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Environment state: ROM wait-state generator and the program counter.
  int          ws = 0;
  int          wcnt = 0;
  bit          rand_mode = 0;
  logic        pre_reset = 0, pre_req = 0, pre_ack = 0, pre_inc = 0, pre_load = 0;
  logic        pre_ready = 0;
  logic [15:0] pre_target = 0;

  // Reference: expected address of the next accepted instruction.
  logic [15:0] exp_addr = 0;
  bit          hold_prev = 0, reqwait_prev = 0;
  logic [15:0] prev_instr = 0, prev_iaddr = 0, prev_raddr = 0;

  task automatic half_a();
    @(negedge clk);
    pre_reset  = reset;
    pre_req    = rom_req;
    pre_ack    = rom_ack;
    pre_inc    = pc_inc;
    pre_load   = pc_load;
    pre_target = pc_target;
    pre_ready  = instr_ready;
    check("pc_inc_load_excl", {31'd0, pc_inc & pc_load}, 0);
    if (pc_load) check("pc_target", pc_target, jump_addr);
    if (hold_prev) begin
      check("hold_valid", instr_valid, 1);
      check("hold_instr", instr, prev_instr);
      check("hold_iaddr", instr_addr, prev_iaddr);
    end
    if (reqwait_prev) begin
      check("req_held", rom_req, 1);
      check("req_addr_stable", rom_addr, prev_raddr);
    end
    hold_prev    = reset && instr_valid && !instr_ready;
    reqwait_prev = reset && rom_req && !rom_ack;
    prev_instr   = instr;
    prev_iaddr   = instr_addr;
    prev_raddr   = rom_addr;
    if (reset && instr_valid && instr_ready) begin
      check("sb_addr", instr_addr, exp_addr);
      check("sb_instr", instr, rom_word(exp_addr));
      $display("ACCEPT cycle=%0d addr=%04h instr=%04h jump=%0d", cycle, instr_addr, instr, jump);
      exp_addr = jump ? jump_addr : exp_addr + 16'd1;
      accepts++;
    end
    if (!reset) exp_addr = 16'h0000;
  endtask

  task automatic half_b();
    @(posedge clk);
    #1;
    cycle++;
    if (!pre_reset)    pc_in = 16'h0000;
    else if (pre_load) pc_in = pre_target;
    else if (pre_inc)  pc_in = pc_in + 16'd1;
    if (!pre_reset || !pre_req || (pre_req && pre_ack)) begin
      wcnt = 0;
      if (rand_mode) ws = $urandom_range(0, 3);
    end else begin
      wcnt++;
    end
    rom_ack  = rom_req && (wcnt >= ws);
    rom_data = rom_word(rom_addr);
    #1;
  endtask

  task automatic tick();
    half_a();
    half_b();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    jump  = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  typedef struct {
    logic        ready;
    logic        jmp;
    logic [15:0] jaddr;
    logic        e_valid;
    logic [15:0] e_iaddr;
    logic        e_inc;
    logic        e_load;
    logic        e_req;
    logic [15:0] e_raddr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int held, last_acc, idle, max_idle, acc_before, guard;
    bit found;
    reset = 1'b0; pc_in = 16'h0; rom_ack = 1'b0; rom_data = 16'h0;
    instr_ready = 1'b1; jump = 1'b0; jump_addr = 16'h0;

    //            rdy jmp jaddr    valid iaddr   inc ld req raddr
    vecs[0]  = '{1'b1, 1'b0, 16'h0,  1'b0, 16'h0,  1'b0, 1'b0, 1'b0, 16'h0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0,  1'b0, 16'h0,  1'b1, 1'b0, 1'b1, 16'h0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0,  1'b1, 16'h0,  1'b1, 1'b0, 1'b1, 16'h1};
    vecs[3]  = '{1'b1, 1'b0, 16'h0,  1'b1, 16'h1,  1'b1, 1'b0, 1'b1, 16'h2};
    vecs[4]  = '{1'b1, 1'b0, 16'h0,  1'b1, 16'h2,  1'b1, 1'b0, 1'b1, 16'h3};
    vecs[5]  = '{1'b1, 1'b0, 16'h0,  1'b1, 16'h3,  1'b1, 1'b0, 1'b1, 16'h4};
    vecs[6]  = '{1'b1, 1'b0, 16'h0,  1'b1, 16'h4,  1'b1, 1'b0, 1'b1, 16'h5};
    vecs[7]  = '{1'b0, 1'b0, 16'h0,  1'b1, 16'h5,  1'b1, 1'b0, 1'b1, 16'h6};
    vecs[8]  = '{1'b1, 1'b1, 16'h40, 1'b1, 16'h5,  1'b0, 1'b1, 1'b0, 16'h6};
    vecs[9]  = '{1'b1, 1'b0, 16'h0,  1'b0, 16'h0,  1'b1, 1'b0, 1'b1, 16'h40};
    vecs[10] = '{1'b1, 1'b0, 16'h0,  1'b1, 16'h40, 1'b1, 1'b0, 1'b1, 16'h41};

    // Zero-wait ROM from reset, then a jump from head 5 with 6 buffered.
    ws = 0; rand_mode = 0;
    do_reset(2);
    for (int i = 0; i < 11; i++) begin
      instr_ready = vecs[i].ready;
      jump        = vecs[i].jmp;
      jump_addr   = vecs[i].jaddr;
      half_a();
      check($sformatf("vec%0d_valid", i), instr_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_iaddr", i), instr_addr, vecs[i].e_iaddr);
        check($sformatf("vec%0d_instr", i), instr, rom_word(vecs[i].e_iaddr));
      end
      check($sformatf("vec%0d_pc_inc", i), pc_inc, vecs[i].e_inc);
      check($sformatf("vec%0d_pc_load", i), pc_load, vecs[i].e_load);
      if (vecs[i].e_load) check($sformatf("vec%0d_target", i), pc_target, vecs[i].jaddr);
      check($sformatf("vec%0d_req", i), rom_req, vecs[i].e_req);
      check($sformatf("vec%0d_raddr", i), rom_addr, vecs[i].e_raddr);
      half_b();
    end
    jump = 1'b0;

    // Decode stalls for 10 cycles: buffer saturates, requests stop.
    instr_ready = 1'b1;
    repeat (3) tick();
    instr_ready = 1'b0;
    repeat (10) tick();
    check("stall_req_off", rom_req, 0);
    check("stall_valid", instr_valid, 1);
    instr_ready = 1'b1;
    repeat (10) tick();

    // Three wait states: each request held 4 cycles, one instr per 4 cycles.
    ws = 3;
    do_reset(2);
    held = 0; last_acc = -1;
    repeat (40) begin
      tick();
      if (rom_req) held++;
      if (rom_req && rom_ack) begin
        check("ws3_hold_cycles", held, 4);
        held = 0;
      end
      if (instr_valid && instr_ready) begin
        if (last_acc >= 0) check("ws3_spacing", cycle - last_acc, 4);
        last_acc = cycle;
      end
    end

    // Reset mid-wait with an ack arriving in the reset cycle.
    guard = 0;
    while (!(rom_req && !rom_ack) && guard < 20) begin tick(); guard++; end
    check("midwait_found", guard < 20, 1);
    reset = 1'b0;
    rom_ack = 1'b1;
    tick();
    check("rst_req", rom_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_raddr", rom_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_iaddr", instr_addr, 0);
    reset = 1'b1;
    tick();
    check("restart_req", rom_req, 1);
    check("restart_addr", rom_addr, pc_in);

    // Jump while a 2-wait request to addr 7 is outstanding.
    ws = 2;
    do_reset(2);
    guard = 0;
    while (!(instr_valid && instr_addr == 16'h6 && rom_req && rom_addr == 16'h7 && !rom_ack)
           && guard < 100) begin
      tick(); guard++;
    end
    check("stale_setup", guard < 100, 1);
    jump = 1'b1; jump_addr = 16'h0080;
    half_a();
    check("stale_pc_load", pc_load, 1);
    check("stale_pc_inc", pc_inc, 0);
    half_b();
    jump = 1'b0;
    found = 0; guard = 0;
    while (!found && guard < 20) begin
      if (rom_req && rom_ack && rom_addr == 16'h7) begin
        check("stale_drop_inc", pc_inc, 0);
        found = 1;
      end
      tick(); guard++;
    end
    check("stale_ack_seen", found, 1);
    check("redirect_req", rom_req, 1);
    check("redirect_addr", rom_addr, 16'h0080);
    guard = 0;
    while (!instr_valid && guard < 20) begin tick(); guard++; end
    check("redirect_first_addr", instr_addr, 16'h0080);
    repeat (4) tick();

    // Randomised traffic against the program-order reference.
    rand_mode = 1;
    do_reset(2);
    idle = 0; max_idle = 0;
    repeat (3000) begin
      reset       = ($urandom_range(0, 299) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      jump        = ($urandom_range(0, 6) == 0);
      jump_addr   = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      acc_before  = accepts;
      tick();
      if (!pre_reset || accepts != acc_before) idle = 0;
      else if (pre_ready) idle++;
      if (idle > max_idle) max_idle = idle;
    end
    check("no_stall", max_idle > 30, 0);
    check("progress", accepts > 500, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
